// File: rtl/scalar_dmem_responder.sv
// scalar_dmem_responder
//   Fixed-latency word-addressed data memory serving scalar loads and stores.
//   A request is accepted only while idle. Its fields are captured on the
//   acceptance edge. Exactly LAT cycles later the block answers with a
//   one-cycle dhit pulse.
//
// Parameters
//   WORD_W : data/address width
//   DEPTH  : number of WORD_W words in the memory
//   LAT    : cycles from the acceptance edge to dhit (1..15)
//
// Ports
//   CLK        : clock, rising-edge
//   rst        : synchronous active-high reset. Also clears the memory.
//   dmemREN    : load request
//   dmemWEN    : store request
//   dmemaddr   : byte address of the request
//   dmemstore  : store data
//   dmemload   : load data. Nonzero only with dhit on a legal load.
//   dhit       : one-cycle completion pulse
//   busy       : high from the cycle after acceptance through the dhit cycle
//   err        : error flag. Meaningful only with dhit.
module scalar_dmem_responder #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [WORD_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dmemload,
  output logic              dhit,
  output logic              busy,
  output logic              err
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              cap_ren;
  logic              cap_wen;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_store;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              resp_ren;
  logic              resp_wen;
  logic [WORD_W-1:0] resp_addr;
  logic              resp_err;
  logic [WORD_W-1:0] resp_load;

  // Any of these conditions makes a request illegal:
  //   - both load and store are requested,
  //   - the address is not word aligned,
  //   - the word index is past the end of the memory.
  function automatic logic req_is_err(input logic ren, input logic wen,
                                      input logic [WORD_W-1:0] addr);
    logic [WORD_W-1:0] word_idx;
    word_idx = addr >> 2;
    return (ren && wen) || (addr[1:0] != 2'b00) || (word_idx >= WORD_W'(DEPTH));
  endfunction

  // Outputs are registered on the edge that enters RESP.
  // With LAT=1 that edge is also the acceptance edge, so the captured
  // registers are still stale. In that case the live inputs are used instead.
  // Memory contents cannot change while a request is pending, so reading the
  // memory here gives the same data as reading it during the dhit cycle.
  always_comb begin
    resp_ren  = cap_ren;
    resp_wen  = cap_wen;
    resp_addr = cap_addr;
    if (state == IDLE) begin
      resp_ren  = dmemREN;
      resp_wen  = dmemWEN;
      resp_addr = dmemaddr;
    end
    resp_err  = req_is_err(resp_ren, resp_wen, resp_addr);
    resp_load = '0;
    if (resp_ren && !resp_err) begin
      resp_load = mem[resp_addr[IDX_W+1:2]];
    end
  end

  // Control FSM with registered dhit, busy, err and dmemload.
  // In WAIT the down-counter starts at LAT-1. The FSM moves to RESP on the
  // edge where the counter reads 1.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_ren   <= 1'b0;
      cap_wen   <= 1'b0;
      cap_addr  <= '0;
      cap_store <= '0;
      dhit      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      dmemload  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dhit     <= 1'b0;
          err      <= 1'b0;
          dmemload <= '0;
          if (dmemREN || dmemWEN) begin
            cap_ren   <= dmemREN;
            cap_wen   <= dmemWEN;
            cap_addr  <= dmemaddr;
            cap_store <= dmemstore;
            cnt       <= LAT_M1;
            busy      <= 1'b1;
            if (LAT > 1) begin
              state <= WAIT;
            end else begin
              state    <= RESP;
              dhit     <= 1'b1;
              err      <= resp_err;
              dmemload <= resp_load;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= RESP;
            dhit     <= 1'b1;
            err      <= resp_err;
            dmemload <= resp_load;
          end
        end
        RESP: begin
          state    <= IDLE;
          dhit     <= 1'b0;
          busy     <= 1'b0;
          err      <= 1'b0;
          dmemload <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A legal store commits at the end of its dhit cycle.
  // A reset in that same cycle wins, so nothing is written.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (dhit && cap_wen && !cap_ren && !err) begin
      mem[cap_addr[IDX_W+1:2]] <= cap_store;
    end
  end

endmodule

// File: tb/tb_scalar_dmem_responder.sv
// tb_scalar_dmem_responder
//   Drives scalar_dmem_responder with directed scenarios and then random
//   traffic. Every output is compared each cycle against a transaction-level
//   reference model. The model tracks the accepted request, the cycle it was
//   accepted in, and a plain array standing in for the memory.
module tb_scalar_dmem_responder;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  logic              CLK;
  logic              rst;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic [WORD_W-1:0] dmemload;
  logic              dhit;
  logic              busy;
  logic              err;

  scalar_dmem_responder #(.WORD_W(WORD_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dmemload  (dmemload),
    .dhit      (dhit),
    .busy      (busy),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hits     = 0;

  // Reference model state.
  logic [WORD_W-1:0] mem_model [DEPTH];
  bit                pend = 0;
  int                ta   = 0;
  logic              p_ren;
  logic              p_wen;
  logic [WORD_W-1:0] p_addr;
  logic [WORD_W-1:0] p_store;

  logic [WORD_W-1:0] last_load;
  logic              last_err;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, actual, expected);
    end
  endtask

  function automatic bit modelErr(input logic ren, input logic wen,
                                  input logic [WORD_W-1:0] addr);
    return (ren && wen) || (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  // One cycle of stimulus.
  // Step 1: at the falling edge, compare the DUT outputs for this cycle with
  //         the model.
  // Step 2: drive this cycle's inputs.
  // Step 3: advance the model to account for the next rising edge.
  task automatic applyStimulus(input logic r, input logic ren, input logic wen,
                               input logic [WORD_W-1:0] addr,
                               input logic [WORD_W-1:0] store);
    bit                in_op;
    bit                exp_dhit;
    bit                exp_err;
    logic [WORD_W-1:0] exp_load;
    @(negedge CLK);
    in_op    = pend && (cyc > ta) && (cyc <= ta + LAT);
    exp_dhit = pend && (cyc == ta + LAT);
    exp_err  = 1'b0;
    exp_load = '0;
    if (exp_dhit) begin
      exp_err = modelErr(p_ren, p_wen, p_addr);
      if (p_ren && !exp_err) exp_load = mem_model[p_addr / 4];
    end
    checkOutput("dhit", 32'(dhit), 32'(exp_dhit));
    checkOutput("busy", 32'(busy), 32'(in_op));
    checkOutput("err", 32'(err), 32'(exp_err));
    checkOutput("dmemload", dmemload, exp_load);
    if (dhit) begin
      hits++;
      last_load = dmemload;
      last_err  = err;
    end

    rst       = r;
    dmemREN   = ren;
    dmemWEN   = wen;
    dmemaddr  = addr;
    dmemstore = store;

    if (r) begin
      pend = 0;
      foreach (mem_model[i]) mem_model[i] = '0;
    end else begin
      if (exp_dhit) begin
        if (p_wen && !exp_err) mem_model[p_addr / 4] = p_store;
        pend = 0;
      end
      if (!in_op && (ren || wen)) begin
        pend    = 1;
        ta      = cyc;
        p_ren   = ren;
        p_wen   = wen;
        p_addr  = addr;
        p_store = store;
      end
    end
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int h0;
    logic              rr;
    logic              rn;
    logic              wn;
    logic [WORD_W-1:0] ad;
    int                sel;

    rst       = 1'b1;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;
    foreach (mem_model[i]) mem_model[i] = '0;
    @(posedge CLK);
    // The first compared cycle follows the sampled reset and checks the reset state.
    // A request is also presented in this reset cycle. It must not be accepted.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    idleCycles(3);

    // Store 0xDEADBEEF to 0x10, then read it back.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    idleCycles(3);
    checkOutput("store_err", 32'(last_err), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    idleCycles(3);
    checkOutput("load_data", last_load, 32'hDEADBEEF);

    // Misaligned load.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
    idleCycles(3);
    checkOutput("misalign_err", 32'(last_err), 32'h1);
    // Out-of-range store. It must not alias onto word 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 32'h1);
    idleCycles(3);
    checkOutput("range_err", 32'(last_err), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idleCycles(3);
    checkOutput("no_alias", last_load, 32'h0);

    // Simultaneous load and store requests.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
    idleCycles(3);
    checkOutput("dual_err", 32'(last_err), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    idleCycles(3);
    checkOutput("dual_nowrite", last_load, 32'h0);

    // Address changes while the load is pending. The captured address must be used.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
    idleCycles(2);
    checkOutput("captured_addr", last_load, 32'hDEADBEEF);

    // Reset during WAIT discards the pending store.
    h0 = hits;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 32'h77);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idleCycles(3);
    checkOutput("rst_no_dhit", 32'(hits - h0), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    idleCycles(3);
    checkOutput("rst_no_write", last_load, 32'h0);

    // REN held high continuously gives one dhit every LAT+1 cycles.
    h0 = hits;
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    idleCycles(1);
    checkOutput("b2b_hits", 32'(hits - h0), 32'd3);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      rr  = ($urandom_range(0, 49) == 0);
      rn  = ($urandom_range(0, 9) < 4);
      wn  = ($urandom_range(0, 9) < 4);
      sel = $urandom_range(0, 9);
      if (sel < 7)       ad = WORD_W'($urandom_range(0, 15)) << 2;
      else if (sel == 7) ad = WORD_W'($urandom_range(0, 63));
      else if (sel == 8) ad = 32'h400 + (WORD_W'($urandom_range(0, 15)) << 2);
      else               ad = $urandom;
      applyStimulus(rr, rn, wn, ad, $urandom);
    end
    idleCycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scalar_dmem_responder.md
SCALAR_DMEM_RESPONDER -- requirements
Module: scalar_dmem_responder

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data/address word width.
REQ-002 SHALL have parameter DEPTH, default 256, number of WORD_W words in the internal data memory.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..15, cycles from request acceptance to dhit.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port dmemREN  input  1  scalar load request from scalar load/store FU.
REQ-007 SHALL have port dmemWEN  input  1  scalar store request from scalar load/store FU.
REQ-008 SHALL have port dmemaddr  input  WORD_W  byte address of request.
REQ-009 SHALL have port dmemstore  input  WORD_W  store data.
REQ-010 SHALL have port dmemload  output  WORD_W  load data, valid only while dhit=1.
REQ-011 SHALL have port dhit  output  1  one-cycle completion pulse for the accepted request.
REQ-012 SHALL have port busy  output  1  high in WAIT and RESP states.
REQ-013 SHALL have port err  output  1  error flag, valid only while dhit=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 SHALL accept a request in IDLE when dmemREN|dmemWEN=1, capturing dmemREN, dmemWEN, dmemaddr and dmemstore into internal registers that same edge.
REQ-016 SHALL ignore all request inputs outside IDLE; input changes in WAIT/RESP have no effect on the pending operation.
REQ-017 SHALL, on acceptance, load a down-counter with LAT-1 and enter WAIT if LAT>1, else enter RESP directly.
REQ-018 SHALL decrement the counter each WAIT cycle and enter RESP when the counter reads 1 at the clock edge.
REQ-019 SHALL assert dhit for exactly one cycle, in RESP, LAT cycles after the acceptance edge (request sampled in cycle t -> dhit=1 in cycle t+LAT), then return to IDLE.
REQ-020 SHALL treat a request still asserted in the cycle after dhit as a new request and accept it (back-to-back throughput one request per LAT+1 cycles).
REQ-021 SHALL flag err=1 on the dhit cycle when: both REN and WEN captured high; captured addr[1:0]!=0; or captured addr>>2 >= DEPTH.
REQ-022 SHALL, for an error request, perform no memory write and drive dmemload=0.
REQ-023 SHALL, for a legal load, drive dmemload = mem[addr>>2] read in the dhit cycle, err=0.
REQ-024 SHALL, for a legal store, write mem[addr>>2] = captured dmemstore at the end of the dhit cycle, drive dmemload=0, err=0.
REQ-025 SHALL drive dmemload=0 and err=0 in every cycle where dhit=0.
REQ-026 SHALL drive busy=1 from the cycle after acceptance through the dhit cycle inclusive, busy=0 in IDLE.
REQ-027 SHALL index memory with log2(DEPTH) bits of addr starting at bit 2; upper bits used only for range check.

Reset
REQ-028 SHALL on rst=1 at a clock edge: state<=IDLE, counter<=0, captured request cleared, all memory words<=0.
REQ-029 SHALL drive dhit=0, busy=0, err=0, dmemload=0 in the cycle after reset is sampled.
REQ-030 SHALL, on reset during WAIT or RESP, discard the pending operation with no memory write and no dhit.
REQ-031 SHALL give rst priority over a simultaneous request; a request asserted in the reset cycle is not accepted.

Verification (LAT=2, DEPTH=256)
REQ-032 SHALL cover store/load: WEN, addr=0x10, store=0xDEADBEEF at t -> dhit at t+2, err=0; then REN addr=0x10 -> dmemload=0xDEADBEEF with dhit, err=0.
REQ-033 SHALL cover errors: REN addr=0x13 -> dhit, err=1, dmemload=0; WEN addr=0x400 store=0x1 -> err=1, subsequent load of 0x0 returns 0.
REQ-034 SHALL cover dual request: REN=WEN=1 addr=0x20 store=0x55 -> err=1, mem[8] still 0.
REQ-035 SHALL cover input instability: REN addr=0x10 at t, addr changed to 0x20 at t+1 -> returned data is mem[4]; busy=1 at t+1 and t+2.
REQ-036 SHALL cover reset mid-op: WEN addr=0x40 store=0x77 at t, rst=1 at t+1 -> no dhit at t+2, later load of 0x40 returns 0.
REQ-037 SHALL cover back-to-back: REN held high continuously -> dhit at t+2, t+5, t+8, each one cycle wide.
